// File: rtl/moore_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter written as an explicit Moore machine.
// One binary-encoded state per count value; count is decoded from the current state only.
module moore_counter #(
  parameter int WIDTH       = 2,
  parameter int MAX_COUNT   = 2**WIDTH-1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  typedef logic [WIDTH-1:0] state_t;

  localparam state_t S0     = '0;
  localparam state_t SMAX   = state_t'(MAX_COUNT);
  localparam state_t SRESET = state_t'(RESET_VALUE);
  localparam state_t ONE    = state_t'(1);

  // Reject parameter sets that would give an empty, oversized or unreachable sequence.
  if (MAX_COUNT < 1) begin : g_bad_max_low
    $error("moore_counter: MAX_COUNT must be at least 1");
  end
  if (MAX_COUNT > 2**WIDTH-1) begin : g_bad_max_high
    $error("moore_counter: MAX_COUNT does not fit in WIDTH bits");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > MAX_COUNT) begin : g_bad_reset
    $error("moore_counter: RESET_VALUE must lie in 0..MAX_COUNT");
  end

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset)
      state <= SRESET;
    else
      state <= state_next;
  end

  // Wrap is an explicit compare against the terminal state; any value above it
  // (only possible with a short modulus) falls through to S0 so the machine cannot lock up.
  always_comb begin
    state_next = S0;
    if (state == SMAX)
      state_next = S0;
    else if (state < SMAX)
      state_next = state + ONE;
  end

  always_comb begin
    count = state;
  end

endmodule

// File: tb/tb_moore_counter.sv
// Bench for moore_counter: a default mod-4 instance and a WIDTH=3/MAX=5/RESET=2 instance
// run side by side, with expected counts queued at drive time and compared after each edge.
module tb_moore_counter;

  logic       clk;
  logic       reset_a;
  logic       reset_b;
  logic [1:0] count_a;
  logic [2:0] count_b;

  int errors = 0;
  int checks = 0;

  int qa[$];
  int qb[$];
  int model_a = 0;
  int model_b = 0;

  moore_counter dut_a (
    .clk   (clk),
    .reset (reset_a),
    .count (count_a)
  );

  moore_counter #(
    .WIDTH       (3),
    .MAX_COUNT   (5),
    .RESET_VALUE (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .count (count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives the resets for the coming edge, queues the model's expectation,
  // then compares both instances just after the edge and returns at the next falling edge.
  task automatic applyStimulus(input logic rst_a, input logic rst_b, input string tag);
    int exp_a;
    int exp_b;
    reset_a = rst_a;
    reset_b = rst_b;
    exp_a = rst_a ? 0 : ((model_a == 3) ? 0 : model_a + 1);
    exp_b = rst_b ? 2 : ((model_b == 5) ? 0 : model_b + 1);
    model_a = exp_a;
    model_b = exp_b;
    qa.push_back(exp_a);
    qb.push_back(exp_b);
    @(posedge clk);
    #1;
    if (qa.size() == 0) checkOutput({tag, " A queue empty"}, 1, 0);
    else checkOutput({tag, " A"}, 32'(count_a), qa.pop_front());
    if (qb.size() == 0) checkOutput({tag, " B queue empty"}, 1, 0);
    else checkOutput({tag, " B"}, 32'(count_b), qb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    reset_a = 1'b1;
    reset_b = 1'b1;

    applyStimulus(1'b1, 1'b1, "reset");

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, "count");

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, "wrap");

    guard = 0;
    while (model_a != 2 && guard < 8) begin
      applyStimulus(1'b0, 1'b0, "seek");
      guard++;
    end
    checkOutput("seek reached 2", 32'(count_a), 2);

    applyStimulus(1'b1, 1'b1, "midreset1");
    applyStimulus(1'b1, 1'b1, "midreset2");
    applyStimulus(1'b0, 1'b0, "release");

    // Reset pulses that start and end between edges must not disturb count.
    for (int i = 0; i < 3; i++) begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      #2;
      checkOutput("stable during pulse A", 32'(count_a), model_a);
      checkOutput("stable during pulse B", 32'(count_b), model_b);
      reset_a = 1'b0;
      reset_b = 1'b0;
      #1;
      checkOutput("stable after pulse A", 32'(count_a), model_a);
      checkOutput("stable after pulse B", 32'(count_b), model_b);
      applyStimulus(1'b0, 1'b0, "post pulse");
    end

    applyStimulus(1'b0, 1'b1, "reset B only");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
